// File: rtl/branch_cond_pkg.sv
// Shared definitions for the conditional-branch evaluation unit:
// condition-code encodings, FSM state type and default geometry.
package branch_cond_pkg;

    localparam int DATA_W_DEFAULT   = 32;
    localparam int COND_LSB_DEFAULT = 19;

    // 3-bit condition field encodings (X compared against Y)
    localparam logic [2:0] COND_EQ     = 3'b000;
    localparam logic [2:0] COND_NE     = 3'b001;
    localparam logic [2:0] COND_GE     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GT     = 3'b100;
    localparam logic [2:0] COND_LE     = 3'b101;
    localparam logic [2:0] COND_GEU    = 3'b110;
    localparam logic [2:0] COND_ALWAYS = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HAVE_A = 2'b01,
        RESULT = 2'b10
    } state_e;

    // Extract the condition field from an instruction word.
    function automatic logic [2:0] cond_field(input logic [31:0] ir, input int lsb);
        return ir[lsb +: 3];
    endfunction

endpackage

// File: rtl/branch_cond_unit_if.sv
// Request/result bundle between the control unit (master) and the
// branch condition unit (slave).
interface branch_cond_unit_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       ir;
    logic [DATA_W-1:0] bus;
    logic              opa_in;
    logic              con_in;
    logic              con_two;
    logic              con_ack;
    logic              flush;
    logic              con_out;
    logic              con_valid;
    logic              have_a;
    logic              proto_err;

    modport master (
        output ir, bus, opa_in, con_in, con_two, con_ack, flush,
        input  con_out, con_valid, have_a, proto_err
    );

    modport slave (
        input  ir, bus, opa_in, con_in, con_two, con_ack, flush,
        output con_out, con_valid, have_a, proto_err
    );
endinterface

// File: rtl/cond_compare.sv
// Purely combinational 8-way condition evaluator: X versus Y, full width,
// signed codes use true two's-complement magnitude comparison.
module cond_compare
    import branch_cond_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [2:0]        code,
    output logic              taken
);

    // Select the comparison named by the condition code.
    always_comb begin
        // NOTE: default assignment first so no path leaves taken unassigned (no latch).
        taken = 1'b0;
        case (code)
            COND_EQ:     taken = (x == y);
            COND_NE:     taken = (x != y);
            COND_GE:     taken = ($signed(x) >= $signed(y));
            COND_LT:     taken = ($signed(x) <  $signed(y));
            COND_GT:     taken = ($signed(x) >  $signed(y));
            COND_LE:     taken = ($signed(x) <= $signed(y));
            COND_GEU:    taken = (x >= y);
            COND_ALWAYS: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Conditional-branch evaluation unit: latches an optional operand A,
// evaluates the IR-selected condition, holds the CON flag and hands it to
// the control unit through a valid/ack handshake with sticky error flag.
module branch_cond_unit
    import branch_cond_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int COND_LSB = COND_LSB_DEFAULT
) (
    input  logic              clk,
    input  logic              clr,
    branch_cond_unit_if.slave bif
);

    state_e            state_q;
    logic [DATA_W-1:0] a_q;
    logic              con_out_q;
    logic              con_valid_q;
    logic              have_a_q;
    logic              proto_err_q;

    logic [2:0]        cond_code;
    logic [DATA_W-1:0] cmp_x;
    logic [DATA_W-1:0] cmp_y;
    logic              taken;
    logic              evaluate;
    logic              slot_free;
    logic              two_missing_a;
    logic              unused_ir;

    assign cond_code = cond_field(bif.ir, COND_LSB);
    assign unused_ir = ^bif.ir;

    // Operand mux: two-operand compares A with bus, otherwise bus with zero.
    always_comb begin
        cmp_x = bif.bus;
        cmp_y = '0;
        if (bif.con_two) begin
            cmp_x = a_q;
            cmp_y = bif.bus;
        end
    end

    cond_compare #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .x     (cmp_x),
        .y     (cmp_y),
        .code  (cond_code),
        .taken (taken)
    );

    // A new request may start unless a result is pending and not acknowledged now.
    assign evaluate      = bif.con_in | bif.con_two;
    assign slot_free     = (state_q != RESULT) | bif.con_ack;
    assign two_missing_a = bif.con_two & (state_q != HAVE_A);

    // Handshake FSM with operand register, CON flag and sticky protocol error.
    always_ff @(posedge clk or negedge clr) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!clr) begin
            state_q     <= IDLE;
            a_q         <= '0;
            con_out_q   <= 1'b0;
            con_valid_q <= 1'b0;
            have_a_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else if (bif.flush) begin
            // Abort keeps the operand value but forgets that it was latched.
            state_q     <= IDLE;
            con_out_q   <= 1'b0;
            con_valid_q <= 1'b0;
            have_a_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HAVE_A, RESULT: begin
                    if (evaluate) begin
                        if (!slot_free || two_missing_a) begin
                            proto_err_q <= 1'b1;
                            // An ack given alongside a rejected request still retires the result.
                            if (slot_free && state_q == RESULT) begin
                                state_q     <= IDLE;
                                con_valid_q <= 1'b0;
                            end
                        end else begin
                            con_out_q   <= taken;
                            state_q     <= RESULT;
                            con_valid_q <= 1'b1;
                            have_a_q    <= 1'b0;
                        end
                    end else if (bif.opa_in) begin
                        if (slot_free) begin
                            a_q         <= bif.bus;
                            state_q     <= HAVE_A;
                            have_a_q    <= 1'b1;
                            con_valid_q <= 1'b0;
                        end else begin
                            proto_err_q <= 1'b1;
                        end
                    end else if (state_q == RESULT && bif.con_ack) begin
                        state_q     <= IDLE;
                        con_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    con_valid_q <= 1'b0;
                    have_a_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bif.con_out   = con_out_q;
    assign bif.con_valid = con_valid_q;
    assign bif.have_a    = have_a_q;
    assign bif.proto_err = proto_err_q;

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
Parametrised conditional-branch evaluation unit for the CPU datapath. It is the successor to the single-operand CON flip-flop.
- Evaluates an 8-way condition selected by an IR field.
- Compares either bus-vs-zero (one-operand branches) or latched-operand-vs-bus (two-operand compare-and-branch).
- Holds the CON result in a register and reports it to the control unit through a valid/ack handshake, with sticky protocol-error detection.

Parameters:
DATA_W, 32, width of bus and operand A register
COND_LSB, 19, bit position of the 3-bit condition field in ir

Ports:
clk  in  1  system clock, all state updates on rising edge
clr  in  1  asynchronous active-low reset
ir  in  32  instruction register; condition field = ir[COND_LSB+2:COND_LSB]
bus  in  DATA_W  datapath bus
opa_in  in  1  latch bus into operand A register
con_in  in  1  evaluate condition: bus vs 0
con_two  in  1  evaluate condition: operand A vs bus
con_ack  in  1  control unit consumes current result
flush  in  1  synchronous abort
con_out  out  1  registered CON flag
con_valid  out  1  result pending acknowledgement
have_a  out  1  operand A latched and not yet consumed
proto_err  out  1  sticky protocol error

Behaviour:
- Reset (clr=0, async): state=IDLE; A=0; con_out=0; con_valid=0; have_a=0; proto_err=0.
- Condition codes compare X against Y. One-operand: X=bus, Y=0. Two-operand: X=A, Y=bus.
  - 000 eq
  - 001 ne
  - 010 ge signed
  - 011 lt signed
  - 100 gt signed
  - 101 le signed
  - 110 geu unsigned
  - 111 always (1)
- All comparisons are full DATA_W wide. Signed codes use two's complement; no overflow artefacts (true magnitude compare, not subtraction sign).
- States and outputs:
  - IDLE: have_a=0, con_valid=0.
  - HAVE_A: have_a=1, con_valid=0.
  - RESULT: con_valid=1, have_a=0.
- Per-cycle priority: flush > evaluate (con_in/con_two) > opa_in.
- flush: next state IDLE; con_out=0, con_valid=0, have_a=0, proto_err=0. A retains its value.
- Evaluate is accepted when state is IDLE or HAVE_A, or when state is RESULT with con_ack=1 in the same cycle (back-to-back).
  - On accept: con_out <= result at the edge; next state RESULT.
  - Latency: 1 edge from request to con_out/con_valid visible.
- con_in accepted in HAVE_A: A is discarded (have_a falls).
- con_two in IDLE (no A latched): ignored; proto_err <= 1; con_out unchanged.
- con_in and con_two asserted together: con_two wins if have_a=1; otherwise treat as the con_two error case.
- Evaluate in RESULT without con_ack: dropped; proto_err <= 1; con_out/con_valid unchanged.
- con_ack in RESULT alone: next state IDLE. con_out holds its value until the next accepted evaluation or flush, so branch logic may sample it any time.
- con_ack outside RESULT: ignored, no error.
- opa_in (no evaluate that cycle):
  - IDLE/HAVE_A: A <= bus; next state HAVE_A (overwrite allowed).
  - RESULT with con_ack: A <= bus; next state HAVE_A.
  - RESULT without con_ack: ignored; proto_err <= 1.
- proto_err is sticky; cleared only by flush or reset.
- Reset mid-operation: immediate return to reset values regardless of state; no clk edge required.
- Illegal state encodings recover to IDLE.

Decomposition:
- Package branch_cond_pkg:
  - 3-bit condition-code localparams (COND_EQ..COND_ALWAYS)
  - state enum (IDLE, HAVE_A, RESULT)
  - default COND_LSB
- Sub-module cond_compare, purely combinational: inputs x, y [DATA_W], code[3]; output taken. Instantiated once; operand mux in parent.
- Parent holds the FSM, A register, con_out, and proto_err.

Test Plan:
- One-operand sweep: ir field 011 (lt), bus=32'hFFFF_FFFF, con_in pulse -> next edge con_out=1, con_valid=1. Then con_ack -> con_valid=0, con_out stays 1. Repeat code 010 with bus=0 -> con_out=1; code 000 with bus=5 -> con_out=0.
- Two-operand: opa_in with bus=32'h8000_0000 -> have_a=1. Then con_two, code 100 (gt signed), bus=1 -> con_out=0. Repeat with code 110 (geu) -> con_out=1 (0x80000000 >= 1 unsigned).
- Back-to-back: in RESULT, con_ack and con_in the same cycle with code 111 -> stays RESULT, con_valid stays 1, con_out=1, proto_err=0.
- Protocol errors, each separately -> proto_err=1 and con_out unchanged:
  - con_two from IDLE
  - con_in in RESULT without ack
  - opa_in in RESULT without ack
  Then flush -> proto_err=0, con_out=0, state IDLE.
- Priority: flush+con_in+opa_in same cycle -> IDLE, con_valid=0, A unchanged. con_in+opa_in in HAVE_A -> RESULT, have_a=0.
- Async reset: assert clr=0 mid-cycle while in RESULT with con_out=1 -> con_out, con_valid, have_a, proto_err all 0 before the next clk edge. Release -> IDLE.
